regfile_2r1w_sb: RTL and testbench
==================================

Name: regfile_2r1w_sb

Overview:
- Parametrised successor to the 8x16 single-port register file for the Simple RISC Machine datapath.
- Provides two independent combinational read ports (A, B) for the ALU operand paths.
- Provides one clocked write port and an asynchronous active-high reset that clears all storage.
- Adds a per-register busy scoreboard. The controller uses it to detect read-after-write hazards on multi-cycle instructions.

Parameters:
- DATA_W, 16: register width in bits.
- NREGS, 8: number of registers; must be a power of two and >= 2.
- ADDR_W, $clog2(NREGS): localparam, not overridable; width of all register indices.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all registers and busy bits.
- data_in  input  DATA_W  write data.
- writenum  input  ADDR_W  write index.
- write  input  1  write enable.
- readnum_a  input  ADDR_W  read index, port A.
- readnum_b  input  ADDR_W  read index, port B.
- data_out_a  output  DATA_W  R[readnum_a].
- data_out_b  output  DATA_W  R[readnum_b].
- reserve  input  1  mark a register as pending.
- reservenum  input  ADDR_W  index to reserve.
- busy_a  output  1  busy bit of readnum_a.
- busy_b  output  1  busy bit of readnum_b.
- busy_vec  output  NREGS  all busy bits; bit i belongs to Ri.

Behaviour:
- Storage: R0..R(NREGS-1), each DATA_W bits.
  - On reset assertion, all registers and busy bits go to 0 immediately, independent of clk.
  - While reset is high, writes and reserves are ignored.
- Write: on posedge clk with write=1 and reset=0, R[writenum] <= data_in. All other registers hold.
- Read: data_out_a, data_out_b, busy_a and busy_b are purely combinational from the current register and busy state.
  - Both ports may address the same register at once.
  - A write to the register being read becomes visible after the edge; the read shows the old value in the same cycle (0-cycle read, 1-cycle write latency).
- Internal one-hot decodes decOutWrite, decOutRead_a and decOutRead_b (NREGS bits each) must exist under these names; the bench probes them hierarchically.
  - decOutWrite is the one-hot of writenum regardless of write.
- Scoreboard, evaluated on posedge clk:
  - If reserve=1, busy[reservenum] <= 1.
  - If write=1, busy[writenum] <= 0.
  - If both target the same index in the same cycle, reserve wins and busy stays 1 (a new producer was issued).
  - Reserve and write to different indices in one cycle: both take effect.
  - Reserving an already-busy register keeps it at 1; there is no count.
  - Writing a non-busy register is legal and leaves its busy bit at 0.
- Reset output values: data_out_a = data_out_b = 0, busy_a = busy_b = 0, busy_vec = 0.
- Reset mid-cycle, including coincident with a clock edge: reset dominates and no write lands.
- busy_vec equals the concatenation of the busy bits with no added latency.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined, write-to-read forwarding applies while write=1 and reset=0:
  - If readnum_x == writenum, data_out_x = data_in and busy_x = 0, combinationally.
  - busy_vec still shows the registered state.
- When undefined, there is no forwarding; reads show stored state only, as described above.

Decomposition:
- Shared package regfile_pkg holds:
  - default constants REGFILE_DATA_W=16 and REGFILE_NREGS=8;
  - typedef reg_idx_t as logic [$clog2(REGFILE_NREGS)-1:0].
- Sub-module dec_onehot: parametrised binary-to-one-hot decoder (N in, 2^N out).
  - Instantiated three times: write, read A, read B.
- Storage, scoreboard and the output muxes stay in the top module.

Test Plan:
- Reset then idle, with readnum_a=3 and readnum_b=5 -> data_out_a=0, data_out_b=0, busy_vec=8'h00.
- Write 42 to R3, then 14 to R1 (one edge each); readnum_a=3, readnum_b=1 -> data_out_a=42, data_out_b=14, decOutRead_a=8'b00001000, decOutWrite=8'b00000010 during the second write.
- write=0, data_in=15, writenum=7 after R7=20 -> R7 stays 20. Same-cycle read of R7 while writing 99 shows 20 without bypass, 99 with REGFILE_BYPASS_EN.
- Reserve R2, next cycle write R2=23 -> busy_vec=8'h04 after the first edge and 8'h00 after the second. Reserve R2 and write R2 on the same edge -> busy stays 1 and R2=23.
- Reserve R4 and write R6=11 on the same edge -> busy_vec=8'h10, R6=11, busy_b=0 with readnum_b=6.
- Assert reset asynchronously mid-high-phase after R5=32 and R5 reserved -> R5 reads 0 and busy_vec=0 immediately, before the next edge. A write held during reset has no effect.
- Parameter sweep DATA_W=32, NREGS=16: write 32'hDEADBEEF to R15 -> data_out_a=32'hDEADBEEF; busy_vec is 16 bits wide.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and index type for the 2-read/1-write register file family.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 16;
    localparam int REGFILE_NREGS  = 8;

    typedef logic [$clog2(REGFILE_NREGS)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_2r1w_sb_dec.sv
// dec_onehot: binary index to one-hot select, N index bits -> 2^N select lines.
module dec_onehot #(
    parameter int N = 3
) (
    input  logic [N-1:0]      idx,
    output logic [2**N-1:0]   onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// NREGS x DATA_W register file: two combinational read ports, one clocked write port,
// per-register busy scoreboard. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W = REGFILE_DATA_W,
    parameter  int NREGS  = REGFILE_NREGS,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] writenum,
    input  logic              write,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reservenum,
    output logic              busy_a,
    output logic              busy_b,
    output logic [NREGS-1:0]  busy_vec
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  decOutWrite;
    logic [NREGS-1:0]  decOutRead_a;
    logic [NREGS-1:0]  decOutRead_b;
    logic [NREGS-1:0]  reserve_sel;
    logic [NREGS-1:0]  clear_sel;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    dec_onehot #(.N(ADDR_W)) u_dec_write (.idx(writenum),  .onehot(decOutWrite));
    dec_onehot #(.N(ADDR_W)) u_dec_rd_a  (.idx(readnum_a), .onehot(decOutRead_a));
    dec_onehot #(.N(ADDR_W)) u_dec_rd_b  (.idx(readnum_b), .onehot(decOutRead_b));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++)
                if (write && decOutWrite[i]) regs[i] <= data_in;
        end
    end

    assign reserve_sel = reserve ? (NREGS'(1) << reservenum) : '0;
    assign clear_sel   = write ? decOutWrite : '0;

    // Set is applied after clear so a same-index reserve keeps the bit busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= (busy & ~clear_sel) | reserve_sel;
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (decOutRead_a[i]) rd_a = rd_a | regs[i];
            if (decOutRead_b[i]) rd_b = rd_b | regs[i];
        end
    end

    always_comb begin
        data_out_a = rd_a;
        data_out_b = rd_b;
        busy_a     = |(busy & decOutRead_a);
        busy_b     = |(busy & decOutRead_b);
`ifdef REGFILE_BYPASS_EN
        if (write && !reset && (readnum_a == writenum)) begin
            data_out_a = data_in;
            busy_a     = 1'b0;
        end
        if (write && !reset && (readnum_b == writenum)) begin
            data_out_b = data_in;
            busy_b     = 1'b0;
        end
`endif
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed bench for regfile_2r1w_sb (default 8x16 and a 16x32 instance), scoreboard-checked.
module tb_regfile_2r1w_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    reg_idx_t    writenum, readnum_a, readnum_b, reservenum;
    logic        write, reserve;
    logic [15:0] data_out_a, data_out_b;
    logic        busy_a, busy_b;
    logic [7:0]  busy_vec;

    logic [31:0] d32_in, d32_a, d32_b;
    logic [3:0]  wn32, ra32, rb32, rn32;
    logic        w32, res32, busy32_a, busy32_b;
    logic [15:0] busy32_vec;

    always #5 clk = ~clk;

    regfile_2r1w_sb dut (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
        .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(data_out_a),
        .data_out_b(data_out_b), .reserve(reserve), .reservenum(reservenum),
        .busy_a(busy_a), .busy_b(busy_b), .busy_vec(busy_vec)
    );

    regfile_2r1w_sb #(.DATA_W(32), .NREGS(16)) dut32 (
        .clk(clk), .reset(reset), .data_in(d32_in), .writenum(wn32), .write(w32),
        .readnum_a(ra32), .readnum_b(rb32), .data_out_a(d32_a),
        .data_out_b(d32_b), .reserve(res32), .reservenum(rn32),
        .busy_a(busy32_a), .busy_b(busy32_b), .busy_vec(busy32_vec)
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic expect_val(input string tag, input logic [31:0] value);
        sb.push_back('{tag: tag, value: value});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_empty: observed %0h with no expected value", obs);
            return;
        end
        e = sb.pop_front();
        n_assert++;
        assert (obs === e.value) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.value);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; data_in = '0; writenum = '0; write = 1'b0;
        readnum_a = 3'd3; readnum_b = 3'd5; reserve = 1'b0; reservenum = '0;
        d32_in = '0; wn32 = '0; w32 = 1'b0; ra32 = '0; rb32 = '0; res32 = 1'b0; rn32 = '0;
        #12 reset = 1'b0;
        tick();

        // Reset state
        expect_val("rst_out_a", 0);  expect_val("rst_out_b", 0);
        expect_val("rst_busy_vec", 0); expect_val("rst_busy_a", 0);
        check(32'(data_out_a)); check(32'(data_out_b));
        check(32'(busy_vec));   check(32'(busy_a));

        // Write R3=42 then R1=14
        write = 1'b1; writenum = 3'd3; data_in = 16'd42;
        tick();
        writenum = 3'd1; data_in = 16'd14;
        #1;
        expect_val("dec_write", 32'h02);
        check(32'(dut.decOutWrite));
        tick();
        write = 1'b0; readnum_a = 3'd3; readnum_b = 3'd1;
        #1;
        expect_val("rd_a_r3", 42); expect_val("rd_b_r1", 14); expect_val("dec_rd_a", 32'h08);
        check(32'(data_out_a)); check(32'(data_out_b)); check(32'(dut.decOutRead_a));

        // decOutWrite follows writenum even with write low
        writenum = 3'd6;
        #1;
        expect_val("dec_write_idle", 32'h40);
        check(32'(dut.decOutWrite));

        // R7=20, then write=0 must not disturb it
        write = 1'b1; writenum = 3'd7; data_in = 16'd20;
        tick();
        write = 1'b0; data_in = 16'd15;
        tick();
        readnum_a = 3'd7; readnum_b = 3'd7;
        #1;
        expect_val("r7_hold_a", 20); expect_val("r7_hold_b", 20);
        check(32'(data_out_a)); check(32'(data_out_b));

        // Same-cycle read of a register being written
        write = 1'b1; data_in = 16'd99;
        #1;
`ifdef REGFILE_BYPASS_EN
        expect_val("same_cycle_rd", 99);
`else
        expect_val("same_cycle_rd", 20);
`endif
        check(32'(data_out_a));
        tick();
        write = 1'b0;
        #1;
        expect_val("r7_after_write", 99);
        check(32'(data_out_a));

        // Reserve R2, then write R2
        reserve = 1'b1; reservenum = 3'd2;
        tick();
        reserve = 1'b0; readnum_a = 3'd2;
        #1;
        expect_val("busy_after_res", 32'h04); expect_val("busy_a_r2", 1);
        check(32'(busy_vec)); check(32'(busy_a));
        write = 1'b1; writenum = 3'd2; data_in = 16'd23;
        tick();
        write = 1'b0;
        #1;
        expect_val("busy_after_wr", 0); expect_val("r2_val", 23);
        check(32'(busy_vec)); check(32'(data_out_a));

        // Reserve and write same index on one edge: reserve wins
        reserve = 1'b1; reservenum = 3'd2; write = 1'b1; writenum = 3'd2; data_in = 16'd23;
        tick();
        reserve = 1'b0; write = 1'b0;
        #1;
        expect_val("same_idx_busy", 32'h04); expect_val("same_idx_val", 23);
        check(32'(busy_vec)); check(32'(data_out_a));
        write = 1'b1;
        tick();
        write = 1'b0;

        // Reserve R4 and write R6 on the same edge
        reserve = 1'b1; reservenum = 3'd4; write = 1'b1; writenum = 3'd6; data_in = 16'd11;
        tick();
        reserve = 1'b0; write = 1'b0; readnum_b = 3'd6;
        #1;
        expect_val("diff_idx_busy", 32'h10); expect_val("r6_val", 11); expect_val("busy_b_r6", 0);
        check(32'(busy_vec)); check(32'(data_out_b)); check(32'(busy_b));

        // Re-reserving a busy register and writing a non-busy one
        reserve = 1'b1; reservenum = 3'd4; write = 1'b1; writenum = 3'd0; data_in = 16'd5;
        tick();
        reserve = 1'b0; write = 1'b0;
        #1;
        expect_val("rereserve_busy", 32'h10);
        check(32'(busy_vec));

        // R5=32 and reserve R5, then async reset mid-high-phase
        write = 1'b1; writenum = 3'd5; data_in = 16'd32;
        tick();
        write = 1'b0; reserve = 1'b1; reservenum = 3'd5;
        tick();
        reserve = 1'b0; readnum_a = 3'd5;
        #1;
        expect_val("r5_pre_rst", 32); expect_val("busy_pre_rst", 32'h30);
        check(32'(data_out_a)); check(32'(busy_vec));
        write = 1'b1; writenum = 3'd5; data_in = 16'd77;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        expect_val("r5_async_rst", 0); expect_val("busy_async_rst", 0);
        check(32'(data_out_a)); check(32'(busy_vec));
        tick();
        reset = 1'b0; write = 1'b0;
        #1;
        expect_val("r5_write_in_rst", 0); expect_val("busy_a_in_rst", 0);
        check(32'(data_out_a)); check(32'(busy_a));

        // 16 x 32 instance
        w32 = 1'b1; wn32 = 4'd15; d32_in = 32'hDEADBEEF; res32 = 1'b1; rn32 = 4'd15;
        tick();
        w32 = 1'b0; res32 = 1'b0; ra32 = 4'd15; rb32 = 4'd14;
        #1;
        expect_val("w32_r15", 32'hDEADBEEF); expect_val("w32_r14", 0);
        expect_val("w32_busy_vec", 32'h8000); expect_val("w32_busy_a", 1);
        check(d32_a); check(d32_b); check(32'(busy32_vec)); check(32'(busy32_a));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
